student_iic_target: RTL and testbench

I2C target (responder) for one fixed 7-bit address. It is the bus-side counterpart of the bit-banged `student_iic_ctrl` initiator. It watches open-drain SCL/SDA, detects START/STOP, matches the address, shifts write bytes out to local logic and shifts read bytes in from local logic. ACK is generated by pulling SDA low. It sits next to the initiator on the board-level I2C bus and does not stretch the clock.

---
 rtl/student_iic_target.sv | 191 +++++++++++++++++++
 tb/tb_student_iic_target.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_iic_target.sv
// I2C target for a single fixed 7-bit address; samples open-drain SCL/SDA on clk_i,
// ACKs by pulling SDA low, and never stretches the clock.
module student_iic_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy_o,
    output logic       addr_hit_o,
    output logic       rw_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRxData,
        StRxAck,
        StTxData,
        StTxAck,
        StWaitStop
    } state_e;

    state_e      state;
    logic [1:0]  scl_s, sda_s;
    logic        scl_prev, sda_prev;
    logic [2:0]  bit_cnt;
    logic [1:0]  phase;
    logic [7:0]  sreg;

    logic        scl_rise, scl_fall, start_det, stop_det, sda_now;
    logic [7:0]  byte_in;

    // Synchronizers reset to 1 so an idle bus produces no spurious events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s    <= 2'b11;
            sda_s    <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s    <= {scl_s[0], scl_i};
            sda_s    <= {sda_s[0], sda_i};
            scl_prev <= scl_s[1];
            sda_prev <= sda_s[1];
        end
    end

    always_comb begin
        sda_now   = sda_s[1];
        scl_rise  = scl_s[1] & ~scl_prev;
        scl_fall  = ~scl_s[1] & scl_prev;
        start_det = scl_s[1] & scl_prev & sda_prev & ~sda_s[1];
        stop_det  = scl_s[1] & scl_prev & ~sda_prev & sda_s[1];
        byte_in   = {sreg[6:0], sda_now};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= StIdle;
            bit_cnt    <= 3'd0;
            phase      <= 2'd0;
            sreg       <= 8'h00;
            sda_oe     <= 1'b0;
            busy_o     <= 1'b0;
            addr_hit_o <= 1'b0;
            rw_o       <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h00;
            tx_req_o   <= 1'b0;
        end else begin
            addr_hit_o <= 1'b0;
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            if (stop_det) begin
                state  <= StIdle;
                sda_oe <= 1'b0;
                busy_o <= 1'b0;
            end else if (start_det) begin
                state   <= StAddr;
                bit_cnt <= 3'd0;
                phase   <= 2'd0;
                sda_oe  <= 1'b0;
                busy_o  <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise) begin
                            sreg    <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_in[7:1] == ADDR) begin
                                    addr_hit_o <= 1'b1;
                                    rw_o       <= byte_in[0];
                                    phase      <= 2'd0;
                                    state      <= StAddrAck;
                                end else begin
                                    state <= StWaitStop;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (phase == 2'd0) begin
                                sda_oe <= 1'b1;
                                phase  <= 2'd1;
                            end else if (rw_o) begin
                                tx_req_o <= 1'b1;
                                sreg     <= tx_data_i;
                                sda_oe   <= ~tx_data_i[7];
                                bit_cnt  <= 3'd0;
                                state    <= StTxData;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= StRxData;
                            end
                        end
                    end
                    StRxData: begin
                        if (scl_rise) begin
                            sreg    <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data_o  <= byte_in;
                                rx_valid_o <= 1'b1;
                                phase      <= 2'd0;
                                state      <= StRxAck;
                            end
                        end
                    end
                    StRxAck: begin
                        if (scl_fall) begin
                            if (phase == 2'd0) begin
                                sda_oe <= 1'b1;
                                phase  <= 2'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= StRxData;
                            end
                        end
                    end
                    StTxData: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                phase <= 2'd0;
                                state <= StTxAck;
                            end
                        end else if (scl_fall) begin
                            sreg   <= {sreg[6:0], 1'b0};
                            sda_oe <= ~sreg[6];
                        end
                    end
                    StTxAck: begin
                        // phase 0: release after bit0, 1: sample master ACK, 2: load next byte
                        if (phase == 2'd0 && scl_fall) begin
                            sda_oe <= 1'b0;
                            phase  <= 2'd1;
                        end else if (phase == 2'd1 && scl_rise) begin
                            if (sda_now) begin
                                state <= StWaitStop;
                            end else begin
                                phase <= 2'd2;
                            end
                        end else if (phase == 2'd2 && scl_fall) begin
                            tx_req_o <= 1'b1;
                            sreg     <= tx_data_i;
                            sda_oe   <= ~tx_data_i[7];
                            bit_cnt  <= 3'd0;
                            state    <= StTxData;
                        end
                    end
                    StWaitStop: sda_oe <= 1'b0;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_student_iic_target.sv
// Bench for student_iic_target: a bit-level I2C master drives the bus, a transaction-level
// model fills scoreboard queues, and a monitor pops them as the target pulses its outputs.
module tb_student_iic_target;

    localparam logic [6:0] TADDR = 7'h50;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_i, scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, busy_o, addr_hit_o, rw_o, rx_valid_o, tx_req_o;
    logic [7:0] rx_data_o, tx_data_i;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    student_iic_target #(.ADDR(TADDR)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .busy_o     (busy_o),
        .addr_hit_o (addr_hit_o),
        .rw_o       (rw_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .tx_req_o   (tx_req_o),
        .tx_data_i  (tx_data_i)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic       exp_hit_q[$];
    logic [7:0] exp_rx_q[$];
    int         exp_tx_cnt = 0;
    logic       quiet = 1'b0;
    logic       quiet_viol = 1'b0;
    logic [7:0] wr_bytes[$];
    logic [7:0] rd_bytes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (quiet && sda_oe) quiet_viol = 1'b1;
        if (addr_hit_o) begin
            check("addr_hit expected", exp_hit_q.size() > 0, 1);
            if (exp_hit_q.size() > 0) check("rw_o", rw_o, exp_hit_q.pop_front());
        end
        if (rx_valid_o) begin
            check("rx_valid expected", exp_rx_q.size() > 0, 1);
            if (exp_rx_q.size() > 0) check("rx_data_o", rx_data_o, exp_rx_q.pop_front());
        end
        if (tx_req_o) begin
            check("tx_req expected", exp_tx_cnt > 0, 1);
            if (exp_tx_cnt > 0) exp_tx_cnt--;
        end
    end

    task automatic qw(input int n = 1);
        repeat (n * Q) @(posedge clk);
        #2;
    endtask

    task automatic start_c();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw(2);
    endtask

    task automatic wbit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw(2);
        scl_m = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_bus; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
    endtask

    task automatic end_txn();
        stop_c();
        check("busy after stop", busy_o, 0);
        check("sda_oe quiet window", quiet_viol, 0);
        quiet = 1'b0;
        quiet_viol = 1'b0;
    endtask

    // Write transaction of wr_bytes to address a; a matched address ACKs everything.
    task automatic do_write(input logic [6:0] a);
        logic hit, ack;
        hit = (a == TADDR);
        if (hit) exp_hit_q.push_back(1'b0);
        quiet = !hit;
        start_c();
        check("busy after start", busy_o, 1);
        wbyte({a, 1'b0}, ack);
        check("write addr ack", ack, hit ? 0 : 1);
        foreach (wr_bytes[i]) begin
            if (hit) exp_rx_q.push_back(wr_bytes[i]);
            wbyte(wr_bytes[i], ack);
            check("write data ack", ack, hit ? 0 : 1);
        end
        end_txn();
    endtask

    // Read transaction: master ACKs every byte except the last.
    task automatic do_read(input logic [6:0] a);
        logic hit, ack;
        logic [7:0] d;
        hit = (a == TADDR);
        tx_data_i = rd_bytes[0];
        if (hit) begin
            exp_hit_q.push_back(1'b1);
            exp_tx_cnt++;
        end
        quiet = !hit;
        start_c();
        wbyte({a, 1'b1}, ack);
        check("read addr ack", ack, hit ? 0 : 1);
        if (!hit) begin
            end_txn();
            return;
        end
        foreach (rd_bytes[i]) begin
            rbyte(d);
            check("read byte", d, rd_bytes[i]);
            if (i == rd_bytes.size() - 1) begin
                wbit(1'b1);
                quiet = 1'b1;
            end else begin
                tx_data_i = rd_bytes[i + 1];
                exp_tx_cnt++;
                wbit(1'b0);
            end
        end
        end_txn();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic [6:0] a;
        logic [7:0] d;
        rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy_o, 0);
        check("reset pulses", {addr_hit_o, rx_valid_o, tx_req_o, rw_o}, 0);
        check("reset rx_data", rx_data_o, 8'h00);
        rst_i = 1'b0;
        qw(2);

        wr_bytes = '{8'hA5, 8'h3C};
        do_write(TADDR);
        check("rx_data holds", rx_data_o, 8'h3C);

        rd_bytes = '{8'h96, 8'h0F};
        do_read(TADDR);

        wr_bytes = '{8'h77};
        do_write(7'h51);

        // Repeated START after a write, then a single-byte read
        exp_hit_q.push_back(1'b0);
        start_c();
        wbyte({TADDR, 1'b0}, ack);
        check("rs addr ack", ack, 0);
        exp_rx_q.push_back(8'h12);
        wbyte(8'h12, ack);
        check("rs data ack", ack, 0);
        tx_data_i = 8'hC3;
        exp_hit_q.push_back(1'b1);
        exp_tx_cnt++;
        start_c();
        check("sda_oe after rstart", sda_oe, 0);
        wbyte({TADDR, 1'b1}, ack);
        check("rs read addr ack", ack, 0);
        rbyte(d);
        check("rs read byte", d, 8'hC3);
        wbit(1'b1);
        quiet = 1'b1;
        end_txn();

        // Reset while the address ACK is being driven
        exp_hit_q.push_back(1'b0);
        start_c();
        for (int i = 7; i >= 0; i--) wbit(((TADDR << 1) >> i) & 1);
        sda_m = 1'b1;
        qw();
        check("sda_oe in addr ack", sda_oe, 1);
        #4 rst_i = 1'b1;
        #1 check("sda_oe async reset", sda_oe, 0);
        qw();
        scl_m = 1'b1; sda_m = 1'b1;
        qw();
        rst_i = 1'b0;
        qw();
        check("busy after reset", busy_o, 0);
        wr_bytes = '{8'h5A};
        do_write(TADDR);

        // STOP after four data bits
        exp_hit_q.push_back(1'b0);
        start_c();
        wbyte({TADDR, 1'b0}, ack);
        check("midstop addr ack", ack, 0);
        for (int i = 0; i < 4; i++) wbit(i[0]);
        end_txn();
        wr_bytes = '{8'hE1};
        do_write(TADDR);

        for (int t = 0; t < 10; t++) begin
            a = TADDR;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == TADDR) a = a ^ 7'h01;
            end
            wr_bytes.delete();
            rd_bytes.delete();
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                wr_bytes.push_back(8'($urandom));
                rd_bytes.push_back(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) do_read(a);
            else do_write(a);
        end

        qw(2);
        check("addr_hit all seen", exp_hit_q.size(), 0);
        check("rx_valid all seen", exp_rx_q.size(), 0);
        check("tx_req all seen", exp_tx_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
